// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle instruction sequencer.
// Fetches a word, presents it to the decoder for one cycle, then samples the
// decoder/ALU controls. It optionally waits for a register writeback (bounded
// by WB_TIMEOUT) and finally commits the next PC and the retire count.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned WB_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [5:0]  opcode,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        jump,
    input  logic        branch,
    input  logic [31:0] alu_result,
    input  logic        register_write,
    input  logic        writeback_done,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        wb_error
);

    localparam int unsigned CW = (WB_TIMEOUT < 2) ? 1 : $clog2(WB_TIMEOUT);
    localparam logic [CW-1:0] WB_LAST = CW'(WB_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_COMMIT
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   npc_q, npc_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   retired_q, retired_d;
    logic          wb_error_q, wb_error_d;
    logic [CW-1:0] wb_cnt_q, wb_cnt_d;
    logic          imem_req_q, imem_req_d;
    logic          instr_valid_q, instr_valid_d;

    logic [31:0]   pc_plus4;
    logic [31:0]   br_target;
    logic [31:0]   jmp_target;

    // Next-state and registered-output computation for the sequencer FSM.
    // Outputs are derived from the state being entered so they are valid
    // from the first cycle of that state; imem_req is held low for the first
    // cycle after reset, and a fetch is only accepted while it is high.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        npc_d         = npc_q;
        instr_d       = instr_q;
        retired_d     = retired_q;
        wb_error_d    = wb_error_q;
        wb_cnt_d      = wb_cnt_q;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;

        pc_plus4   = pc_q + 32'd4;
        br_target  = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        jmp_target = {pc_plus4[31:28], instr_q[25:0], 2'b00};

        case (state_q)
            S_FETCH: begin
                if (imem_req_q && imem_ready) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = S_DECODE;
                end else begin
                    imem_req_d = 1'b1;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (jump) begin
                    npc_d = jmp_target;
                end else if (branch && (|alu_result)) begin
                    npc_d = br_target;
                end else begin
                    npc_d = pc_plus4;
                end
                wb_cnt_d = '0;
                state_d  = register_write ? S_WRITEBACK : S_COMMIT;
            end
            S_WRITEBACK: begin
                if (writeback_done) begin
                    state_d = S_COMMIT;
                end else if (wb_cnt_q == WB_LAST) begin
                    wb_error_d = 1'b1;
                    state_d    = S_COMMIT;
                end else begin
                    wb_cnt_d = wb_cnt_q + 1'b1;
                end
            end
            S_COMMIT: begin
                pc_d       = npc_q;
                retired_d  = retired_q + 32'd1;
                imem_req_d = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            npc_q         <= RESET_PC;
            instr_q       <= '0;
            retired_q     <= '0;
            wb_error_q    <= 1'b0;
            wb_cnt_q      <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            npc_q         <= npc_d;
            instr_q       <= instr_d;
            retired_q     <= retired_d;
            wb_error_q    <= wb_error_d;
            wb_cnt_q      <= wb_cnt_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign retired     = retired_q;
    assign wb_error    = wb_error_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter WB_TIMEOUT, default 16: max cycles waited for writeback_done before flagging an error.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address, equal to pc.
REQ-007 imem_ready  input  1  read data valid this cycle.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 opcode  output  6  instr[31:26], driven to the control decoder.
REQ-010 instr  output  32  latched instruction word.
REQ-011 instr_valid  output  1  one-cycle pulse when a new instruction is presented.
REQ-012 jump, branch  input  1 each  decoder outputs for the current instruction.
REQ-013 alu_result  input  32  ALU result; branch taken when nonzero (bne).
REQ-014 register_write  input  1  current instruction writes a register.
REQ-015 writeback_done  input  1  register file has committed the write.
REQ-016 pc  output  32  address of the current instruction.
REQ-017 retired  output  32  count of committed instructions.
REQ-018 wb_error  output  1  sticky; set on writeback timeout.

Function
REQ-019 SHALL implement the states FETCH, DECODE, EXECUTE, WRITEBACK and COMMIT.
REQ-020 FETCH: imem_req=1; on imem_ready=1 latch imem_rdata into instr and go to DECODE; otherwise hold, with no time limit.
REQ-021 DECODE: instr_valid=1 for exactly this cycle; imem_req=0; go to EXECUTE next cycle.
REQ-022 EXECUTE: sample jump, branch, alu_result and register_write. If register_write=1, go to WRITEBACK; otherwise go to COMMIT.
REQ-023 WRITEBACK: wait for writeback_done=1, then go to COMMIT.
REQ-024 WRITEBACK timeout: after WB_TIMEOUT cycles without writeback_done, set wb_error and go to COMMIT.
REQ-025 COMMIT: update pc and increment retired (modulo 2^32), then go to FETCH.
REQ-026 Next-PC priority, highest first:
 - jump: {pc_plus4[31:28], instr[25:0], 2'b00}
 - branch with alu_result!=0: pc_plus4 + (signext(instr[15:0]) << 2)
 - otherwise: pc_plus4 = pc + 4
REQ-027 All PC arithmetic SHALL be 32-bit with silent wrap-around (32'hFFFF_FFFC + 4 = 0).
REQ-028 Latency with imem_ready in the same cycle as the request and no writeback: 4 cycles per instruction (F, D, E, C). A writeback adds 1 + n wait cycles.
REQ-029 Control inputs SHALL be ignored outside EXECUTE. writeback_done SHALL be ignored outside WRITEBACK.
REQ-030 jump=1 and branch=1 together: jump wins.
REQ-031 imem_ready=1 outside FETCH SHALL be ignored; instr remains unchanged.
REQ-032 opcode SHALL always equal instr[31:26] combinationally.

Reset
REQ-033 reset=1 SHALL asynchronously force the following values, regardless of state (including mid-fetch or mid-writeback):
 - state=FETCH, pc=RESET_PC, instr=0, retired=0, wb_error=0, instr_valid=0
 - the WRITEBACK wait counter cleared
REQ-034 imem_req SHALL be 0 while reset is asserted and rise in the first clk edge cycle after deassertion.
REQ-035 Reset SHALL discard any in-flight instruction; retired is not incremented for it.

Verification
REQ-036 R-type add (opcode 0), imem_ready immediate, writeback_done 2 cycles after WRITEBACK entry -> pc 0->4, retired=1, instr_valid single pulse, 7 cycles total.
REQ-037 j with instr=32'h0800_0010 at pc=0 -> pc=32'h0000_0040, no WRITEBACK state.
REQ-038 bne with imm=16'hFFFF at pc=8: alu_result=5 -> pc=8; alu_result=0 -> pc=12.
REQ-039 register_write=1 with writeback_done held low -> wb_error=1 after 16 WRITEBACK cycles, pc advances by 4, wb_error stays set.
REQ-040 pc=32'hFFFF_FFFC, sequential instruction (sw) -> pc=0, retired increments.
REQ-041 reset pulsed in WRITEBACK while imem_ready toggles -> pc=RESET_PC, retired=0, imem_req=0 during reset, fetch restarts cleanly.
